// File: rtl/pong_pkg.sv
// Shared pong constants, colours, BCD FSM state type and geometry helpers.
// Game logic imports the same constants so both ends agree on the playfield.
package pong_pkg;

    typedef logic [10:0] coord_t;

    localparam coord_t SCREEN_W     = 11'd480;
    localparam coord_t SCREEN_H     = 11'd272;
    localparam coord_t BALL_SIZE    = 11'd10;
    localparam coord_t PADDLE_W     = 11'd10;
    localparam coord_t PADDLE_H     = 11'd60;
    localparam coord_t PADDLE_L_X   = 11'd20;
    localparam coord_t PADDLE_R_X   = SCREEN_W - 11'd20 - PADDLE_W;
    localparam coord_t SCORE_Y      = 11'd8;
    localparam coord_t DIGIT_W      = 11'd12;
    localparam coord_t DIGIT_H      = 11'd20;
    localparam coord_t SEG_T        = 11'd2;
    localparam coord_t DIG_LT_X     = 11'd200;
    localparam coord_t DIG_LU_X     = 11'd216;
    localparam coord_t DIG_RT_X     = 11'd256;
    localparam coord_t DIG_RU_X     = 11'd272;
    localparam coord_t NET_X        = 11'd239;
    localparam coord_t NET_W        = 11'd2;

    localparam logic [9:0] BALL_RST_X   = 10'd240;
    localparam logic [9:0] BALL_RST_Y   = 10'd136;
    localparam logic [9:0] PADDLE_RST_Y = 10'd106;

    localparam logic [15:0] COL_BALL   = 16'hFFFF;
    localparam logic [15:0] COL_PADDLE = 16'h07E0;
    localparam logic [15:0] COL_SCORE  = 16'hFFE0;
    localparam logic [15:0] COL_NET    = 16'h8410;
    localparam logic [15:0] COL_BG     = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV_L,
        ST_CONV_R,
        ST_DONE
    } bcd_state_t;

    // Segment order is {a,b,c,d,e,f,g}.
    function automatic logic [6:0] seg7_decode(input logic [3:0] digit);
        logic [6:0] segs;
        case (digit)
            4'd0:    segs = 7'b1111110;
            4'd1:    segs = 7'b0110000;
            4'd2:    segs = 7'b1101101;
            4'd3:    segs = 7'b1111001;
            4'd4:    segs = 7'b0110011;
            4'd5:    segs = 7'b1011011;
            4'd6:    segs = 7'b1011111;
            4'd7:    segs = 7'b1110000;
            4'd8:    segs = 7'b1111111;
            4'd9:    segs = 7'b1111011;
            default: segs = 7'b0000000;
        endcase
        return segs;
    endfunction

    function automatic logic in_span(input coord_t p, input coord_t org, input coord_t len);
        return (p >= org) && (p < org + len);
    endfunction

    function automatic logic digit_hit(input coord_t px, input coord_t py,
                                       input coord_t ox, input logic [6:0] segs);
        coord_t u;
        coord_t v;
        logic   upper;
        logic   lit;
        u     = px - ox;
        v     = py - SCORE_Y;
        upper = (v < DIGIT_H / 11'd2);
        lit   = (segs[6] && v < SEG_T)
             || (segs[5] && u >= DIGIT_W - SEG_T && upper)
             || (segs[4] && u >= DIGIT_W - SEG_T && !upper)
             || (segs[3] && v >= DIGIT_H - SEG_T)
             || (segs[2] && u < SEG_T && !upper)
             || (segs[1] && u < SEG_T && upper)
             || (segs[0] && v >= 11'd9 && v < 11'd11);
        return in_span(px, ox, DIGIT_W) && in_span(py, SCORE_Y, DIGIT_H) && lit;
    endfunction

endpackage

// File: rtl/pong_score_bcd.sv
// Iterative 7-bit score to {tens,units} converter, clamping inputs above 99.
// i_start loads a value and overrides any conversion in flight; o_done is a one-cycle pulse
// during which o_tens/o_units hold the result.
module pong_score_bcd
(
    input  logic       clk_pix,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic [6:0] i_value,
    output logic       o_done,
    output logic [3:0] o_tens,
    output logic [3:0] o_units
);
    import pong_pkg::*;

    logic [6:0] r_rem;
    logic [3:0] r_tens;
    logic       r_busy;
    logic [6:0] w_clamped;

    assign w_clamped = (i_value > 7'd99) ? 7'd99 : i_value;
    assign o_done    = r_busy && (r_rem < 7'd10);
    assign o_tens    = r_tens;
    assign o_units   = r_rem[3:0];

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            r_rem  <= 7'd0;
            r_tens <= 4'd0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_rem  <= w_clamped;
            r_tens <= 4'd0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            if (r_rem >= 7'd10) begin
                r_rem  <= r_rem - 7'd10;
                r_tens <= r_tens + 4'd1;
            end else begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pong_renderer.sv
// Pong pixel renderer: per-frame game-state snapshot, BCD score FSM, 2-stage hit/colour pipe.
// Define PONG_CENTER_NET_EN to draw the dashed centre net.
module pong_renderer
(
    input  logic        clk_pix,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic        de_in,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic        game_active,
    input  logic [9:0]  ball_x,
    input  logic [9:0]  ball_y,
    input  logic [9:0]  paddle_left_y,
    input  logic [9:0]  paddle_right_y,
    input  logic [6:0]  score_left,
    input  logic [6:0]  score_right,
    output logic        de_out,
    output logic [15:0] rgb,
    output logic        snap_ready
);
    import pong_pkg::*;

    logic [9:0] r_ball_x, r_ball_y, r_pad_l_y, r_pad_r_y;
    logic       r_active;
    logic [6:0] r_score_r;

    // Active defaults high so the reset snapshot shows the centred ball before any frame.
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            r_ball_x  <= BALL_RST_X;
            r_ball_y  <= BALL_RST_Y;
            r_pad_l_y <= PADDLE_RST_Y;
            r_pad_r_y <= PADDLE_RST_Y;
            r_active  <= 1'b1;
            r_score_r <= 7'd0;
        end else if (frame_start) begin
            r_ball_x  <= ball_x;
            r_ball_y  <= ball_y;
            r_pad_l_y <= paddle_left_y;
            r_pad_r_y <= paddle_right_y;
            r_active  <= game_active;
            r_score_r <= score_right;
        end
    end

    bcd_state_t r_state;
    logic       r_snap_ready;
    logic [3:0] r_pend_lt, r_pend_lu, r_pend_rt, r_pend_ru;
    logic [3:0] r_dig_lt, r_dig_lu, r_dig_rt, r_dig_ru;
    logic       w_bcd_start, w_bcd_done;
    logic [6:0] w_bcd_value;
    logic [3:0] w_bcd_tens, w_bcd_units;

    // The left score is loaded straight from the port on frame_start, i.e. the snapped value.
    assign w_bcd_start = frame_start || (r_state == ST_CONV_L && w_bcd_done);
    assign w_bcd_value = frame_start ? score_left : r_score_r;

    pong_score_bcd u_bcd (
        .clk_pix (clk_pix),
        .rst_n   (rst_n),
        .i_start (w_bcd_start),
        .i_value (w_bcd_value),
        .o_done  (w_bcd_done),
        .o_tens  (w_bcd_tens),
        .o_units (w_bcd_units)
    );

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_snap_ready <= 1'b0;
            r_pend_lt    <= 4'd0;
            r_pend_lu    <= 4'd0;
            r_pend_rt    <= 4'd0;
            r_pend_ru    <= 4'd0;
            r_dig_lt     <= 4'd0;
            r_dig_lu     <= 4'd0;
            r_dig_rt     <= 4'd0;
            r_dig_ru     <= 4'd0;
        end else if (frame_start) begin
            r_state      <= ST_CONV_L;
            r_snap_ready <= 1'b0;
        end else begin
            case (r_state)
                ST_CONV_L: if (w_bcd_done) begin
                    r_pend_lt <= w_bcd_tens;
                    r_pend_lu <= w_bcd_units;
                    r_state   <= ST_CONV_R;
                end
                ST_CONV_R: if (w_bcd_done) begin
                    r_pend_rt <= w_bcd_tens;
                    r_pend_ru <= w_bcd_units;
                    r_state   <= ST_DONE;
                end
                ST_DONE: begin
                    r_dig_lt     <= r_pend_lt;
                    r_dig_lu     <= r_pend_lu;
                    r_dig_rt     <= r_pend_rt;
                    r_dig_ru     <= r_pend_ru;
                    r_snap_ready <= 1'b1;
                    r_state      <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign snap_ready = r_snap_ready;

    coord_t     w_px, w_py;
    logic       w_hit_ball, w_hit_pad_l, w_hit_pad_r;
    logic [3:0] w_hit_dig;

    assign w_px        = {1'b0, pix_x};
    assign w_py        = {1'b0, pix_y};
    assign w_hit_ball  = r_active && in_span(w_px, {1'b0, r_ball_x}, BALL_SIZE)
                                  && in_span(w_py, {1'b0, r_ball_y}, BALL_SIZE);
    assign w_hit_pad_l = in_span(w_px, PADDLE_L_X, PADDLE_W) && in_span(w_py, {1'b0, r_pad_l_y}, PADDLE_H);
    assign w_hit_pad_r = in_span(w_px, PADDLE_R_X, PADDLE_W) && in_span(w_py, {1'b0, r_pad_r_y}, PADDLE_H);
    // Left tens blanks on a leading zero; right tens always shows.
    assign w_hit_dig[3] = (r_dig_lt != 4'd0) && digit_hit(w_px, w_py, DIG_LT_X, seg7_decode(r_dig_lt));
    assign w_hit_dig[2] = digit_hit(w_px, w_py, DIG_LU_X, seg7_decode(r_dig_lu));
    assign w_hit_dig[1] = digit_hit(w_px, w_py, DIG_RT_X, seg7_decode(r_dig_rt));
    assign w_hit_dig[0] = digit_hit(w_px, w_py, DIG_RU_X, seg7_decode(r_dig_ru));

    logic       r_de1, r_hit_ball, r_hit_pad_l, r_hit_pad_r;
    logic [3:0] r_hit_dig;

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            r_de1       <= 1'b0;
            r_hit_ball  <= 1'b0;
            r_hit_pad_l <= 1'b0;
            r_hit_pad_r <= 1'b0;
            r_hit_dig   <= 4'd0;
        end else begin
            r_de1       <= de_in;
            r_hit_ball  <= w_hit_ball;
            r_hit_pad_l <= w_hit_pad_l;
            r_hit_pad_r <= w_hit_pad_r;
            r_hit_dig   <= w_hit_dig;
        end
    end

`ifdef PONG_CENTER_NET_EN
    logic w_hit_net;
    logic r_hit_net;

    assign w_hit_net = in_span(w_px, NET_X, NET_W) && !pix_y[3];

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) r_hit_net <= 1'b0;
        else        r_hit_net <= w_hit_net;
    end
`endif

    logic [15:0] w_colour;

    always_comb begin
        w_colour = COL_BG;
        if (r_hit_ball)                     w_colour = COL_BALL;
        else if (r_hit_pad_l || r_hit_pad_r) w_colour = COL_PADDLE;
        else if (|r_hit_dig)                w_colour = COL_SCORE;
`ifdef PONG_CENTER_NET_EN
        else if (r_hit_net)                 w_colour = COL_NET;
`endif
    end

    logic        r_de_out;
    logic [15:0] r_rgb;

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            r_de_out <= 1'b0;
            r_rgb    <= 16'h0000;
        end else begin
            r_de_out <= r_de1;
            r_rgb    <= r_de1 ? w_colour : 16'h0000;
        end
    end

    assign de_out = r_de_out;
    assign rgb    = r_rgb;

endmodule

// File: tb/tb_pong_renderer.sv
// Directed bench for pong_renderer: expected {de_out,rgb} words queued at drive time and
// checked two clocks later; snapshot/BCD timing checked on snap_ready.
module tb_pong_renderer;

    localparam logic [15:0] WHITE  = 16'hFFFF;
    localparam logic [15:0] GREEN  = 16'h07E0;
    localparam logic [15:0] YELLOW = 16'hFFE0;
    localparam logic [15:0] BLACK  = 16'h0000;
`ifdef PONG_CENTER_NET_EN
    localparam logic [15:0] NET_COL = 16'h8410;
`else
    localparam logic [15:0] NET_COL = 16'h0000;
`endif

    logic        clk_pix = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        de_in = 1'b0;
    logic [9:0]  pix_x = 10'd0;
    logic [9:0]  pix_y = 10'd0;
    logic        game_active = 1'b1;
    logic [9:0]  ball_x = 10'd0;
    logic [9:0]  ball_y = 10'd0;
    logic [9:0]  paddle_left_y = 10'd0;
    logic [9:0]  paddle_right_y = 10'd0;
    logic [6:0]  score_left = 7'd0;
    logic [6:0]  score_right = 7'd0;
    logic        de_out;
    logic [15:0] rgb;
    logic        snap_ready;

    pong_renderer dut (
        .clk_pix        (clk_pix),
        .rst_n          (rst_n),
        .frame_start    (frame_start),
        .de_in          (de_in),
        .pix_x          (pix_x),
        .pix_y          (pix_y),
        .game_active    (game_active),
        .ball_x         (ball_x),
        .ball_y         (ball_y),
        .paddle_left_y  (paddle_left_y),
        .paddle_right_y (paddle_right_y),
        .score_left     (score_left),
        .score_right    (score_right),
        .de_out         (de_out),
        .rgb            (rgb),
        .snap_ready     (snap_ready)
    );

    // Clock / cycle counter
    always #5 clk_pix = ~clk_pix;

    int cyc = 0;
    always @(posedge clk_pix) cyc <= cyc + 1;

    // Scoreboard
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [16:0] exp_q[$];
    int          due_q[$];
    string       tag_q[$];
    int          snap_rises = 0;
    logic        snap_prev = 1'b0;

    task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk_pix) begin : sb_monitor
        logic [16:0] e;
        string       t;
        if (due_q.size() != 0 && due_q[0] == cyc) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            due_q.delete(0);
            check(t, {de_out, rgb}, e);
        end
        if (snap_ready && !snap_prev) snap_rises++;
        snap_prev = snap_ready;
    end

    // Driver tasks
    task automatic pix(input string tag, input int x, input int y, input logic [15:0] col);
        @(negedge clk_pix);
        de_in = 1'b1;
        pix_x = 10'(x);
        pix_y = 10'(y);
        exp_q.push_back({1'b1, col});
        due_q.push_back(cyc + 2);
        tag_q.push_back(tag);
    endtask

    task automatic blank_pix(input string tag, input int x, input int y);
        @(negedge clk_pix);
        de_in = 1'b0;
        pix_x = 10'(x);
        pix_y = 10'(y);
        exp_q.push_back(17'h0);
        due_q.push_back(cyc + 2);
        tag_q.push_back(tag);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) blank_pix("idle", 0, 0);
    endtask

    task automatic new_frame(input int sl, input int sr);
        @(negedge clk_pix);
        de_in       = 1'b0;
        score_left  = 7'(sl);
        score_right = 7'(sr);
        frame_start = 1'b1;
        @(negedge clk_pix);
        frame_start = 1'b0;
    endtask

    task automatic wait_snap(input string tag);
        int n;
        n = 0;
        check({tag, "_clr"}, {16'h0, snap_ready}, 17'h0);
        while (!snap_ready && n < 40) begin
            @(negedge clk_pix);
            n++;
        end
        check($sformatf("%s_lat(n=%0d)", tag, n), {16'h0, (snap_ready && n <= 23)}, 17'h1);
    endtask

    initial begin
        int r0;
        // Reset: hold with a hitting pixel on the inputs
        de_in = 1'b1;
        pix_x = 10'd240;
        pix_y = 10'd136;
        repeat (3) @(negedge clk_pix);
        check("rst_pix", {de_out, rgb}, 17'h0);
        check("rst_snap", {16'h0, snap_ready}, 17'h0);
        rst_n = 1'b1;

        // Frame A: reset snapshot (ball 240,136; paddles 106; scores 0/00)
        pix("a_ball_tl", 240, 136, WHITE);
        pix("a_ball_br", 249, 145, WHITE);
        pix("a_ball_xr", 250, 136, BLACK);
        pix("a_ball_yb", 245, 146, BLACK);
        pix("a_ball_xl", 239, 140, BLACK);
        blank_pix("a_de_off", 240, 136);
        pix("a_padl", 25, 110, GREEN);
        pix("a_padl_top", 20, 106, GREEN);
        pix("a_padl_bot", 20, 166, BLACK);
        pix("a_padl_xr", 30, 110, BLACK);
        pix("a_padr", 459, 165, GREEN);
        pix("a_padr_xl", 449, 120, BLACK);
        pix("a_lu0_a", 221, 8, YELLOW);
        pix("a_lt_blank", 205, 8, BLACK);
        pix("a_rt0_a", 261, 8, YELLOW);
        pix("a_ru0_g", 277, 17, BLACK);
        idle(3);

        // Frame B: scores 47 / 9, ball input changed mid-frame afterwards
        ball_x = 10'd100; ball_y = 10'd200;
        paddle_left_y = 10'd100; paddle_right_y = 10'd50;
        game_active = 1'b1;
        new_frame(47, 9);
        wait_snap("b_snap");
        ball_x = 10'd300;
        pix("b_ball", 100, 200, WHITE);
        pix("b_ball_stale", 300, 200, BLACK);
        pix("b_ball_old", 240, 136, BLACK);
        pix("b_padl", 25, 110, GREEN);
        pix("b_padl_above", 25, 99, BLACK);
        pix("b_padr_last", 455, 109, GREEN);
        pix("b_padr_end", 455, 110, BLACK);
        pix("b_lt4_f", 200, 8, YELLOW);
        pix("b_lt4_a", 205, 8, BLACK);
        pix("b_lt4_g", 205, 17, YELLOW);
        pix("b_lu7_a", 221, 8, YELLOW);
        pix("b_lu7_g", 221, 17, BLACK);
        pix("b_rt0_a", 261, 8, YELLOW);
        pix("b_rt0_g", 261, 17, BLACK);
        pix("b_ru9_g", 277, 17, YELLOW);
        pix("b_ru9_e", 272, 20, BLACK);
        pix("b_ru9_f", 272, 12, YELLOW);
        idle(3);

        // Frame C: score 120 clamps to 99; ball over left paddle
        ball_x = 10'd20; ball_y = 10'd105;
        paddle_left_y = 10'd100; paddle_right_y = 10'd200;
        new_frame(120, 5);
        wait_snap("c_snap");
        pix("c_prio", 25, 110, WHITE);
        pix("c_padl", 25, 120, GREEN);
        pix("c_lt9_g", 205, 17, YELLOW);
        pix("c_lt9_e", 200, 20, BLACK);
        pix("c_lu9_g", 221, 17, YELLOW);
        pix("c_lu9_f", 216, 12, YELLOW);
        pix("c_rt0_a", 261, 8, YELLOW);
        pix("c_ru5_b", 282, 12, BLACK);
        pix("c_ru5_f", 272, 12, YELLOW);
        idle(3);

        // Frame D: game inactive, left score 5 (tens blank), right 12
        ball_x = 10'd300; ball_y = 10'd50;
        game_active = 1'b0;
        new_frame(5, 12);
        wait_snap("d_snap");
        pix("d_ball_hidden", 300, 50, BLACK);
        pix("d_lt_blank_a", 205, 8, BLACK);
        pix("d_lt_blank_f", 200, 12, BLACK);
        pix("d_lt_blank_d", 211, 27, BLACK);
        pix("d_lu5_a", 221, 8, YELLOW);
        pix("d_lu5_e", 216, 20, BLACK);
        pix("d_lu5_b", 226, 12, BLACK);
        pix("d_rt1_a", 261, 8, BLACK);
        pix("d_rt1_b", 266, 12, YELLOW);
        pix("d_ru2_e", 272, 20, YELLOW);
        pix("d_ru2_c", 282, 20, BLACK);
        pix("d_net0", 239, 0, NET_COL);
        pix("d_net1", 240, 0, NET_COL);
        idle(3);

        // Frame E: second frame_start lands mid-conversion
        game_active = 1'b1;
        r0 = snap_rises;
        new_frame(30, 40);
        repeat (5) @(negedge clk_pix);
        check("e_snap_mid", {16'h0, snap_ready}, 17'h0);
        new_frame(88, 3);
        wait_snap("e_snap");
        repeat (30) @(negedge clk_pix);
        check("e_snap_once", 17'(snap_rises - r0), 17'h1);
        pix("e_lt8_e", 200, 20, YELLOW);
        pix("e_lt8_g", 205, 17, YELLOW);
        pix("e_rt0_g", 261, 17, BLACK);
        pix("e_ru3_e", 272, 20, BLACK);
        pix("e_ru3_b", 282, 12, YELLOW);
        idle(3);

        for (int i = 0; i < 10 && due_q.size() != 0; i++) @(negedge clk_pix);
        check("drain", 17'(due_q.size()), 17'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
